// File: rtl/frame_buffer.sv
// frame_buffer: captures one frame of up to DEPTH entries, holds it until the
// consumer acks it, and exposes both the entries and a status word on a
// combinational read port. A partial frame can be closed by an idle timeout.
module frame_buffer #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 5,
  parameter int ADDR_W       = 3,
  parameter int TIMEOUT      = 0,
  parameter int DROP_ON_FULL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              ack,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] r_data,
  output logic              frame_rdy,
  output logic [ADDR_W-1:0] count,
  output logic              overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } state_t;

  // The idle counter only needs to reach TIMEOUT; keep it one bit wide when
  // the timeout is disabled so the declaration stays legal.
  localparam int                IDLE_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] STAT_IDX  = ADDR_W'(DEPTH);

  state_t              state;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Frame control FSM, flags and entry storage, all updated on one edge.
  // NOTE: the storage is cleared by the asynchronous reset so a read after
  // reset never returns data from a discarded frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: all sequential state uses non-blocking assignments so every
      // branch below sees the pre-edge values of count, state and idle_cnt.
      state     <= IDLE;
      count     <= '0;
      frame_rdy <= 1'b0;
      overrun   <= 1'b0;
      idle_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ack) overrun <= 1'b0;
          if (wr) begin
            mem[0]   <= w_data;
            count    <= ADDR_W'(1);
            idle_cnt <= '0;
            state    <= FILL;
          end
        end

        FILL: begin
          if (ack) overrun <= 1'b0;
          if (wr) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (count == ADDR_W'(i)) mem[i] <= w_data;
            end
            count    <= count + 1'b1;
            idle_cnt <= '0;
            if (count == LAST_IDX) begin
              state     <= READY;
              frame_rdy <= 1'b1;
            end
          end else if (TIMEOUT > 0) begin
            if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
            if (idle_cnt == IDLE_LAST) begin
              state     <= READY;
              frame_rdy <= 1'b1;
            end
          end
        end

        READY: begin
          if (ack) begin
            // Release takes priority; a simultaneous write opens a new frame.
            overrun   <= 1'b0;
            idle_cnt  <= '0;
            frame_rdy <= 1'b0;
            if (wr) begin
              mem[0] <= w_data;
              count  <= ADDR_W'(1);
              state  <= FILL;
            end else begin
              count <= '0;
              state <= IDLE;
            end
          end else if (wr) begin
            overrun <= 1'b1;
            if (DROP_ON_FULL == 0) begin
              mem[0]    <= w_data;
              count     <= ADDR_W'(1);
              idle_cnt  <= '0;
              frame_rdy <= 1'b0;
              state     <= FILL;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Combinational read: entries below DEPTH, status word at DEPTH, zero above.
  always_comb begin
    // NOTE: default first so every path assigns r_data and no latch is inferred.
    r_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (address == ADDR_W'(i)) r_data = mem[i];
    end
    if (address == STAT_IDX) begin
      r_data[0] = frame_rdy;
      r_data[1] = overrun;
    end
  end

endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer. Instance a: TIMEOUT=4, DROP_ON_FULL=1.
// Instance b: TIMEOUT=0, DROP_ON_FULL=0. Both see the same stimulus.
module tb_frame_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr;
  logic [7:0] w_data;
  logic       ack;
  logic [2:0] address;

  logic [7:0] r_data_a, r_data_b;
  logic       frame_rdy_a, frame_rdy_b;
  logic [2:0] count_a, count_b;
  logic       overrun_a, overrun_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  frame_buffer #(.DATA_W(8), .DEPTH(5), .ADDR_W(3), .TIMEOUT(4), .DROP_ON_FULL(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .wr(wr), .w_data(w_data), .ack(ack), .address(address),
    .r_data(r_data_a), .frame_rdy(frame_rdy_a), .count(count_a), .overrun(overrun_a)
  );

  frame_buffer #(.DATA_W(8), .DEPTH(5), .ADDR_W(3), .TIMEOUT(0), .DROP_ON_FULL(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wr(wr), .w_data(w_data), .ack(ack), .address(address),
    .r_data(r_data_b), .frame_rdy(frame_rdy_b), .count(count_b), .overrun(overrun_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One write cycle; inputs settle 1 ns after the edge.
  task automatic wr_one(input logic [7:0] d, input logic with_ack);
    wr = 1'b1; w_data = d; ack = with_ack;
    @(posedge clk); #1;
    wr = 1'b0; ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [2:0] a);
    address = a;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_full [5];
    exp_full[0] = 8'h11; exp_full[1] = 8'h22; exp_full[2] = 8'h33;
    exp_full[3] = 8'h44; exp_full[4] = 8'h55;

    rst_n = 1'b0; wr = 1'b0; w_data = '0; ack = 1'b0; address = '0;
    #12;
    check("rst_count_a", 32'(count_a), 0);
    check("rst_rdy_a", 32'(frame_rdy_a), 0);
    check("rst_ovr_a", 32'(overrun_a), 0);
    check("rst_count_b", 32'(count_b), 0);
    check("rst_entry0_a", 32'(r_data_a), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full frame of five consecutive writes.
    for (int i = 0; i < 5; i++) wr_one(exp_full[i], 1'b0);
    check("full_rdy_a", 32'(frame_rdy_a), 1);
    check("full_count_a", 32'(count_a), 5);
    check("full_rdy_b", 32'(frame_rdy_b), 1);
    for (int i = 0; i < 5; i++) begin
      set_addr(3'(i));
      check($sformatf("full_entry%0d_a", i), 32'(r_data_a), 32'(exp_full[i]));
    end
    set_addr(3'd5);
    check("full_status_a", 32'(r_data_a), 32'h01);
    set_addr(3'd7);
    check("full_above_a", 32'(r_data_a), 32'h00);

    // Write while pending: a drops it, b starts a new frame over it.
    wr_one(8'h66, 1'b0);
    check("drop_count_a", 32'(count_a), 5);
    check("drop_ovr_a", 32'(overrun_a), 1);
    check("drop_rdy_a", 32'(frame_rdy_a), 1);
    set_addr(3'd0);
    check("drop_entry0_a", 32'(r_data_a), 32'h11);
    check("restart_entry0_b", 32'(r_data_b), 32'h66);
    check("restart_count_b", 32'(count_b), 1);
    check("restart_rdy_b", 32'(frame_rdy_b), 0);
    check("restart_ovr_b", 32'(overrun_b), 1);
    set_addr(3'd1);
    check("restart_entry1_b", 32'(r_data_b), 32'h22);
    set_addr(3'd5);
    check("drop_status_a", 32'(r_data_a), 32'h03);
    check("restart_status_b", 32'(r_data_b), 32'h02);

    // Ack: a releases the frame; b is filling so only overrun clears.
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    check("ack_rdy_a", 32'(frame_rdy_a), 0);
    check("ack_ovr_a", 32'(overrun_a), 0);
    check("ack_count_a", 32'(count_a), 0);
    check("ack_ovr_b", 32'(overrun_b), 0);
    check("ack_count_b", 32'(count_b), 1);
    set_addr(3'd0);
    check("ack_stale_a", 32'(r_data_a), 32'h11);

    // Timeout closes a partial frame on a; b never times out.
    do_reset();
    wr_one(8'hA1, 1'b0);
    wr_one(8'hA2, 1'b0);
    idle(3);
    check("to3_rdy_a", 32'(frame_rdy_a), 0);
    idle(1);
    check("to4_rdy_a", 32'(frame_rdy_a), 1);
    check("to4_count_a", 32'(count_a), 2);
    idle(20);
    check("noto_rdy_b", 32'(frame_rdy_b), 0);
    check("noto_count_b", 32'(count_b), 2);
    set_addr(3'd1);
    check("to_entry1_a", 32'(r_data_a), 32'hA2);

    // Write and ack together on a pending frame.
    wr_one(8'h77, 1'b1);
    check("wrack_count_a", 32'(count_a), 1);
    check("wrack_rdy_a", 32'(frame_rdy_a), 0);
    check("wrack_ovr_a", 32'(overrun_a), 0);
    set_addr(3'd0);
    check("wrack_entry0_a", 32'(r_data_a), 32'h77);
    check("fill_count_b", 32'(count_b), 3);

    // Asynchronous reset mid-fill at count 3.
    wr_one(8'h78, 1'b0);
    wr_one(8'h79, 1'b0);
    check("pre_rst_count_a", 32'(count_a), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_count_a", 32'(count_a), 0);
    check("async_entry0_a", 32'(r_data_a), 0);
    check("async_rdy_b", 32'(frame_rdy_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wr_one(8'h5A, 1'b0);
    check("post_rst_entry0_a", 32'(r_data_a), 32'h5A);
    check("post_rst_count_a", 32'(count_a), 1);
    set_addr(3'd1);
    check("post_rst_entry1_a", 32'(r_data_a), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
